// File: rtl/matrix_pkg.sv
// Shared definitions for the 8x8 block transform engines (encoder and decoder).
// Holds geometry, accumulator widths, FSM states and the element packing offset.
package matrix_pkg;
   localparam int N      = 8;
   localparam int ELEM_W = 8;
   localparam int T_W    = 19;
   localparam int Y_W    = 30;
   localparam int BLK_W  = N * N * ELEM_W;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_PASS1 = 3'd2,
      ST_PASS2 = 3'd3,
      ST_PACK  = 3'd4
   } state_e;

   function automatic int elem_off(input int i, input int j);
      return (i * N + j) * ELEM_W;
   endfunction
endpackage

// File: rtl/inv_matrix_transform_mac_unit.sv
// Signed multiply-accumulate: sum = acc + a*b, with the product kept at full width.
module mac_unit #(
   parameter int A_W   = 19,
   parameter int B_W   = 8,
   parameter int ACC_W = 30
) (
   input  logic signed [A_W-1:0]   a,
   input  logic signed [B_W-1:0]   b,
   input  logic signed [ACC_W-1:0] acc,
   output logic signed [ACC_W-1:0] sum
);
   logic signed [A_W+B_W-1:0] prod;

   assign prod = a * b;
   assign sum  = acc + {{(ACC_W-A_W-B_W){prod[A_W+B_W-1]}}, prod};
endmodule

// File: rtl/inv_matrix_transform.sv
// Decoder-side 8x8 inverse transform: A = clamp(((B^T*C*B) >>> SHIFT) + 128, 0, 255),
// computed one MAC per clock by a single shared mac_unit sequenced through two passes.
module inv_matrix_transform
   import matrix_pkg::*;
#(
   parameter int SHIFT = 0
) (
   input  logic             Clock,
   input  logic             reset,
   input  logic             start,
   input  logic [BLK_W-1:0] C,
   input  logic [BLK_W-1:0] B,
   output logic [BLK_W-1:0] A,
   output logic             busy,
   output logic             done
);
   state_e state;
   logic [8:0] cnt;
   logic [2:0] ii, jj, kk;

   logic signed [ELEM_W-1:0] c_m [N][N];
   logic signed [ELEM_W-1:0] b_m [N][N];
   logic signed [T_W-1:0]    t_m [N][N];
   logic signed [Y_W-1:0]    y_m [N][N];

   logic signed [T_W-1:0]    mac_a;
   logic signed [ELEM_W-1:0] mac_b;
   logic signed [Y_W-1:0]    mac_acc, mac_sum;
   logic [BLK_W-1:0]         a_pack;

   // k innermost, then j, then i: the nine-bit counter walks all 512 steps in order
   assign ii = cnt[8:6];
   assign jj = cnt[5:3];
   assign kk = cnt[2:0];

   always_comb begin
      mac_a   = T_W'(b_m[kk][ii]);
      mac_b   = c_m[kk][jj];
      mac_acc = Y_W'(t_m[ii][jj]);
      if (state == ST_PASS2) begin
         mac_a   = t_m[ii][kk];
         mac_b   = b_m[kk][jj];
         mac_acc = y_m[ii][jj];
      end
   end

   mac_unit #(.A_W(T_W), .B_W(ELEM_W), .ACC_W(Y_W)) u_mac (
      .a   (mac_a),
      .b   (mac_b),
      .acc (mac_acc),
      .sum (mac_sum)
   );

   // Final normalise, offset and clamp; Y is sign-extended one bit so +128 cannot overflow
   for (genvar gi = 0; gi < N; gi++) begin : g_row
      for (genvar gj = 0; gj < N; gj++) begin : g_col
         logic signed [Y_W:0] ofs;
         assign ofs = ($signed({y_m[gi][gj][Y_W-1], y_m[gi][gj]}) >>> SHIFT)
                      + $signed((Y_W+1)'(128));
         assign a_pack[elem_off(gi, gj) +: ELEM_W] =
            ofs[Y_W] ? '0 : (|ofs[Y_W-1:ELEM_W]) ? '1 : ofs[ELEM_W-1:0];
      end
   end

   always_ff @(posedge Clock) begin
      if (reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
         A     <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: if (start) state <= ST_LOAD;
            ST_LOAD: begin
               for (int r = 0; r < N; r++) begin
                  for (int s = 0; s < N; s++) begin
                     c_m[r][s] <= C[elem_off(r, s) +: ELEM_W];
                     b_m[r][s] <= B[elem_off(r, s) +: ELEM_W];
                     t_m[r][s] <= '0;
                     y_m[r][s] <= '0;
                  end
               end
               cnt   <= '0;
               busy  <= 1'b1;
               state <= ST_PASS1;
            end
            ST_PASS1: begin
               t_m[ii][jj] <= mac_sum[T_W-1:0];
               cnt         <= cnt + 9'd1;
               if (&cnt) state <= ST_PASS2;
            end
            ST_PASS2: begin
               y_m[ii][jj] <= mac_sum;
               cnt         <= cnt + 9'd1;
               if (&cnt) state <= ST_PACK;
            end
            ST_PACK: begin
               A     <= a_pack;
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_inv_matrix_transform.sv
// Self-checking bench for inv_matrix_transform: directed spec cases plus random blocks
// against a plain-arithmetic matrix model, with SHIFT=0 and SHIFT=3 instances.
module tb_inv_matrix_transform;
   logic         Clock = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic [511:0] C = '0, B = '0;
   logic [511:0] A, A3;
   logic         busy, done, busy3, done3;
   int           tests = 0, fails = 0;

   always #5 Clock = ~Clock;

   inv_matrix_transform #(.SHIFT(0)) dut (
      .Clock(Clock), .reset(reset), .start(start), .C(C), .B(B),
      .A(A), .busy(busy), .done(done)
   );
   inv_matrix_transform #(.SHIFT(3)) dut3 (
      .Clock(Clock), .reset(reset), .start(start), .C(C), .B(B),
      .A(A3), .busy(busy3), .done(done3)
   );

   function automatic logic [511:0] ref_block(input logic [511:0] c, input logic [511:0] b,
                                              input int sh);
      int cm[8][8], bm[8][8], t[8][8], y[8][8];
      int v;
      logic [511:0] r;
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++) begin
            cm[i][j] = int'($signed(c[(i*8+j)*8 +: 8]));
            bm[i][j] = int'($signed(b[(i*8+j)*8 +: 8]));
         end
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++) begin
            t[i][j] = 0;
            for (int k = 0; k < 8; k++) t[i][j] += bm[k][i] * cm[k][j];
         end
      r = '0;
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++) begin
            y[i][j] = 0;
            for (int k = 0; k < 8; k++) y[i][j] += t[i][k] * bm[k][j];
            v = (y[i][j] >>> sh) + 128;
            if (v < 0) v = 0;
            if (v > 255) v = 255;
            r[(i*8+j)*8 +: 8] = v[7:0];
         end
      return r;
   endfunction

   function automatic logic [511:0] mk_ident(input int scale);
      logic [511:0] r = '0;
      for (int i = 0; i < 8; i++) r[(i*8+i)*8 +: 8] = 8'(scale);
      return r;
   endfunction

   function automatic logic [511:0] mk_fill(input int val);
      logic [511:0] r;
      for (int e = 0; e < 64; e++) r[e*8 +: 8] = 8'(val);
      return r;
   endfunction

   function automatic logic [511:0] mk_rand(input int lo, input int hi);
      logic [511:0] r;
      for (int e = 0; e < 64; e++) r[e*8 +: 8] = 8'(int'($urandom_range(hi - lo)) + lo);
      return r;
   endfunction

   // Pulse start, scramble the sources after LOAD, and wait (bounded) for done.
   task automatic run_block(input logic [511:0] cv, input logic [511:0] bv,
                            output int lat, output logic busy1);
      @(negedge Clock); C = cv; B = bv; start = 1'b1;
      @(negedge Clock); start = 1'b0;
      lat = 0; busy1 = 1'b0;
      while (!done && lat < 2000) begin
         @(negedge Clock); lat++;
         if (lat == 1) busy1 = busy;
         if (lat == 2) begin C = mk_rand(-128, 127); B = mk_rand(-128, 127); end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b1;
      repeat (3) @(negedge Clock);
      tests++;
      if (A !== '0 || busy !== 1'b0 || done !== 1'b0) begin
         fails++; $display("FAIL reset_state: A=%h busy=%b done=%b want 0/0/0", A, busy, done);
      end
      reset = 1'b0; start = 1'b0;
      @(negedge Clock);
      tests++;
      if (busy !== 1'b0) begin
         fails++; $display("FAIL reset_start_wins: busy=%b want 0", busy);
      end
   endtask

   task automatic test_zero();
      int lat; logic b1;
      run_block(mk_fill(0), mk_ident(1), lat, b1);
      tests++;
      if (lat !== 1026) begin fails++; $display("FAIL zero_latency: got %0d want 1026", lat); end
      tests++;
      if (b1 !== 1'b1) begin fails++; $display("FAIL busy_after_load: got %b want 1", b1); end
      tests++;
      if (busy !== 1'b0) begin fails++; $display("FAIL busy_at_done: got %b want 0", busy); end
      tests++;
      if (A !== mk_fill(128)) begin fails++; $display("FAIL zero_A: got %h want all 80", A); end
      @(negedge Clock);
      tests++;
      if (done !== 1'b0) begin fails++; $display("FAIL done_one_cycle: got %b want 0", done); end
   endtask

   task automatic test_passthrough();
      int lat; logic b1;
      logic [511:0] cv, exp;
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++) begin
            cv[(i*8+j)*8 +: 8]  = 8'(i*8 + j - 32);
            exp[(i*8+j)*8 +: 8] = 8'(i*8 + j + 96);
         end
      run_block(cv, mk_ident(1), lat, b1);
      tests++;
      if (A !== exp) begin fails++; $display("FAIL passthrough: got %h want %h", A, exp); end
      tests++;
      if (A3 !== ref_block(cv, mk_ident(1), 3)) begin
         fails++; $display("FAIL passthrough_shift3: got %h want %h", A3, ref_block(cv, mk_ident(1), 3));
      end
   endtask

   task automatic test_saturation();
      int lat; logic b1;
      run_block(mk_fill(127), mk_ident(1), lat, b1);
      tests++;
      if (A !== mk_fill(255)) begin fails++; $display("FAIL sat_high: got %h want all ff", A); end
      run_block(mk_fill(-128), mk_ident(1), lat, b1);
      tests++;
      if (A !== '0) begin fails++; $display("FAIL sat_low: got %h want all 00", A); end
   endtask

   task automatic test_full_basis();
      int lat; logic b1;
      logic [511:0] cv = '0;
      cv[7:0] = 8'd1;
      run_block(cv, mk_fill(1), lat, b1);
      tests++;
      if (A !== mk_fill(129)) begin fails++; $display("FAIL basis_ones: got %h want all 81", A); end
      run_block(mk_fill(16), mk_ident(2), lat, b1);
      tests++;
      if (A3 !== mk_fill(136)) begin fails++; $display("FAIL shift3_2I: got %h want all 88", A3); end
      tests++;
      if (A !== mk_fill(192)) begin fails++; $display("FAIL shift0_2I: got %h want all c0", A); end
   endtask

   task automatic test_random();
      int lat; logic b1;
      logic [511:0] cv, bv;
      for (int n = 0; n < 5; n++) begin
         if (n == 4) begin cv = mk_rand(-128, 127); bv = mk_rand(-128, 127); end
         else begin cv = mk_rand(-24, 24); bv = mk_rand(-2, 2); end
         run_block(cv, bv, lat, b1);
         tests++;
         if (A !== ref_block(cv, bv, 0)) begin
            fails++; $display("FAIL random%0d: got %h want %h", n, A, ref_block(cv, bv, 0));
         end
         tests++;
         if (A3 !== ref_block(cv, bv, 3) || done3 !== 1'b1) begin
            fails++; $display("FAIL random%0d_shift3: got %h done3=%b want %h", n, A3, done3,
                              ref_block(cv, bv, 3));
         end
      end
   endtask

   task automatic test_handshake();
      int lat = 0, first = -1, ndone = 0;
      logic [511:0] cv = mk_rand(-24, 24), bv = mk_rand(-2, 2);
      @(negedge Clock); C = cv; B = bv; start = 1'b1;
      @(negedge Clock); start = 1'b0;
      while (lat < 1100) begin
         @(negedge Clock); lat++;
         start = (lat == 9 || lat == 1024);
         if (done) begin ndone++; if (first < 0) first = lat; end
      end
      start = 1'b0;
      tests++;
      if (first !== 1026 || ndone !== 1) begin
         fails++; $display("FAIL start_while_busy: first done %0d count %0d want 1026 and 1", first, ndone);
      end
      tests++;
      if (A !== ref_block(cv, bv, 0)) begin fails++; $display("FAIL handshake_A: got %h", A); end
   endtask

   task automatic test_back_to_back();
      int lat, gap = 0; logic b1;
      logic [511:0] cv = mk_rand(-24, 24), bv = mk_rand(-2, 2);
      run_block(mk_fill(5), mk_ident(1), lat, b1);
      C = cv; B = bv; start = 1'b1;
      @(negedge Clock); start = 1'b0; gap = 1;
      while (!done && gap < 2000) begin @(negedge Clock); gap++; end
      tests++;
      if (gap !== 1027) begin fails++; $display("FAIL back_to_back_gap: got %0d want 1027", gap); end
      tests++;
      if (A !== ref_block(cv, bv, 0)) begin
         fails++; $display("FAIL back_to_back_A: got %h want %h", A, ref_block(cv, bv, 0));
      end
   endtask

   task automatic test_reset_mid();
      int lat = 0; logic b1;
      logic [511:0] cv = mk_rand(-24, 24), bv = mk_rand(-2, 2);
      @(negedge Clock); C = mk_fill(100); B = mk_ident(1); start = 1'b1;
      @(negedge Clock); start = 1'b0;
      while (lat < 700) begin @(negedge Clock); lat++; end
      reset = 1'b1;
      @(negedge Clock);
      tests++;
      if (A !== '0 || busy !== 1'b0 || done !== 1'b0) begin
         fails++; $display("FAIL reset_mid: A=%h busy=%b done=%b want 0/0/0", A, busy, done);
      end
      reset = 1'b0;
      run_block(cv, bv, lat, b1);
      tests++;
      if (lat !== 1026 || A !== ref_block(cv, bv, 0)) begin
         fails++; $display("FAIL after_abort: lat %0d A %h want 1026 %h", lat, A, ref_block(cv, bv, 0));
      end
   endtask

   initial begin
      test_reset();
      test_zero();
      test_passthrough();
      test_saturation();
      test_full_basis();
      test_random();
      test_handshake();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/inv_matrix_transform.md
# inv_matrix_transform

Decoder-side counterpart of the 8x8 block transform engine: takes a packed 8x8 block of signed coefficients C and the same signed 8x8 basis matrix B used by the encoder, and reconstructs a pixel block A = clamp((Bᵀ·C·B >>> SHIFT) + 128, 0, 255). It sits on the reconstruction path after coefficient storage and before the pixel write-back. It uses a single multiply-accumulate datapath sequenced by an FSM, at one MAC per clock.

## Interface
- SHIFT, 0: arithmetic right shift applied to the second-pass result before the +128 offset (basis normalisation).
- Clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; sampled on the rising edge of Clock.
- start  input  1  one-cycle request; sampled only in IDLE.
- C  input  512  coefficient block, signed 8-bit elements; element (i,j) at bits [(i*8+j)*8 +: 8].
- B  input  512  basis matrix, signed 8-bit elements, same packing.
- A  output  512  reconstructed pixels, unsigned 8-bit, same packing; reset 0.
- busy  output  1  high from the LOAD state through PACK; reset 0.
- done  output  1  one-cycle pulse when A is updated; reset 0.

## Operation
- States: IDLE → LOAD → PASS1 → PASS2 → PACK → IDLE.
- IDLE: busy=0. start=1 → LOAD.
- LOAD (1 cycle): C and B are unpacked into internal 8x8 arrays, T and Y are cleared, and the indices i, j, k are set to 0. C and B are not sampled again until the next LOAD, so the source may change them freely after LOAD.
- PASS1 (512 cycles): T[i][j] += B[k][i]·C[k][j], which computes Bᵀ·C.
  - k is the innermost index, then j, then i.
  - The step with i=j=k=7 moves the FSM to PASS2 and resets the indices.
- PASS2 (512 cycles): Y[i][j] += T[i][k]·B[k][j], using the same index order and exit condition.
- PACK (1 cycle): for every element, A[i][j] = sat_u8((Y[i][j] >>> SHIFT) + 128). done=1 in the following cycle, busy drops, and the FSM returns to IDLE.
- Arithmetic:
  - Products are signed 8x8 → 16 bits.
  - T is 19-bit signed and Y is 30-bit signed. Both are full precision, so there is no wrap.
  - sat_u8 clamps values below 0 to 0 and values above 255 to 255.
- A holds its value until the next PACK or reset.
- start while busy: ignored, not queued.
- start in the same cycle as reset: reset wins.
- reset mid-operation: the next cycle is IDLE with A=0, busy=0, done=0. The internal arrays need not be cleared.
- done and start in the same cycle: the new start is accepted, because the FSM is already in IDLE.

## Timing
- Sequence: start is sampled high at edge 0. LOAD completes at edge 1, PASS1 at edge 513, PASS2 at edge 1025, and PACK at edge 1026. After edge 1026, A is valid and done=1 for one cycle.
- Latency is 1026 cycles from start to done. Back-to-back throughput is one block per 1027 cycles.
- busy is high after edge 1 and low after edge 1026.
- The MAC path may be registered internally only if the 1026-cycle latency is preserved exactly.

## Structure
- The shared package matrix_pkg holds:
  - N=8 and ELEM_W=8;
  - accumulator widths T_W=19 and Y_W=30;
  - the state enum;
  - an element-offset function for the packing (i*N+j)*ELEM_W.
- The encoder engine should import the same package.
- One natural sub-module is mac_unit: a signed multiply plus accumulate with a parameterised width, instantiated once and shared by both passes through operand muxing.
- The saturation logic stays inline in PACK.

## Test plan
- Zero coefficients: B=identity (diagonal 1), C all 0, start → done after 1026 cycles with every element of A equal to 128.
- Pass-through: B=identity, C[i][j]=i*8+j-32 → A[i][j]=i*8+j+96 for every element.
- Saturation: B=identity with C all 127 → A all 255. B=identity with C all −128 → A all 0.
- Full basis: B all 1, C[0][0]=1 and all other elements 0 → A all 129. With SHIFT=3 and B=2·identity, C[i][j]=16 → A all 136.
- Handshake: start pulsed again at cycles 10 and 1025 → ignored, with exactly one done at cycle 1026. start in the done cycle → a second done exactly 1027 cycles later.
- Reset mid-PASS2 (cycle 700) → next cycle A=0, busy=0, done=0. A following start produces a correct result with no residue from the aborted run.
